exception_controller: RTL and testbench
=======================================

EXCEPTION_CONTROLLER -- requirements
Module: exception_controller

Interface
REQ-001 Parameter PC_W, default 16: width of the program counter and exception PC.
REQ-002 Parameter HANDLER_ADDR, default 16'h0100: kernel handler entry address.
REQ-003 Parameter TIMER_PERIOD, default 1000: timer interrupt period in cycles, used only with COPROC_TIMER_EN.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 overflow  in  1  ALU overflow of the instruction at pc, valid for one cycle.
REQ-007 user_input  in  1  level user-input interrupt request.
REQ-008 ie_set / ie_clr  in  1 each  enable-interrupts / disable-interrupts instruction strobes.
REQ-009 eret  in  1  exception-return instruction strobe.
REQ-010 pc  in  PC_W  address of the instruction currently executing.
REQ-011 mode  out  1  0 = user mode, 1 = kernel mode.
REQ-012 flush  out  1  one-cycle pipeline squash pulse.
REQ-013 pc_sel  out  1  fetch redirect; when 1, fetch uses pc_target.
REQ-014 pc_target  out  PC_W  redirect address.
REQ-015 epc  out  PC_W  saved exception PC.
REQ-016 cause  out  2  00 none, 01 overflow, 10 user input, 11 timer.
REQ-017 ie  out  1  interrupts-enabled flag.
REQ-018 ack_user  out  1  one-cycle acknowledge of a taken user-input request.

Function
REQ-019 FSM states SHALL be USER, TAKE, KERNEL and RETURN; flush and pc_sel are high only in TAKE and RETURN.
REQ-020 user_pend SHALL be set while user_input = 1 and cleared on the cycle ack_user pulses.
REQ-021 In USER with ie = 1 and any of overflow, user_pend or timer_pend set, the next state SHALL be TAKE.
REQ-022 Priority SHALL be overflow > user_pend > timer_pend; a losing source stays pending.
REQ-023 On the USER->TAKE edge: epc <= pc, cause <= winning code, ie <= 0, and ack_user pulses in TAKE if the user-input source won.
REQ-024 In TAKE: mode = 1, flush = 1, pc_sel = 1, pc_target = HANDLER_ADDR; the next state SHALL be KERNEL.
REQ-025 Latency from detection at cycle N: redirect at N+1, KERNEL at N+2.
REQ-026 In KERNEL: mode = 1; overflow is ignored and leaves epc/cause unchanged; user_input still sets user_pend.
REQ-027 In KERNEL: eret SHALL move the FSM to RETURN; ie_set and ie_clr are ignored.
REQ-028 In RETURN: mode = 1, flush = 1, pc_sel = 1, pc_target = epc, ie <= 1, cause <= 00; the next state SHALL be USER.
REQ-029 In USER: eret is ignored; ie_set sets ie; ie_clr clears ie; if both strobe in the same cycle, ie_clr wins.
REQ-030 With ie = 0 in USER, overflow SHALL be dropped, not latched.
REQ-031 An ie_set in the same cycle as a pending request SHALL take effect the next cycle, with no take in that cycle.
REQ-032 Outside TAKE and RETURN, pc_target SHALL be 0.

Reset
REQ-033 Reset SHALL set state = USER, mode = 0, ie = 0, epc = 0, cause = 00, flush = 0, pc_sel = 0, ack_user = 0, user_pend = 0, timer_pend = 0 and timer count = 0.
REQ-034 Reset in any state, including TAKE and RETURN, SHALL abort the sequence with no redirect on the following cycle.

Configuration
REQ-035 With COPROC_TIMER_EN defined, a counter SHALL increment each cycle in USER while ie = 1.
REQ-036 When the counter reaches TIMER_PERIOD-1, it SHALL wrap to 0 and set timer_pend; timer_pend clears when a timer take occurs.
REQ-037 Without COPROC_TIMER_EN, no counter SHALL exist, timer_pend is constant 0, cause never equals 11, and ports are unchanged.

Structure
REQ-038 Package coproc_pkg SHALL hold the state encoding, the cause codes and the HANDLER_ADDR default.
REQ-039 Combinational source selection SHALL live in sub-module exc_priority_encoder (inputs overflow/user/timer, outputs take and a 2-bit code).

Verification
REQ-040 ie = 1, overflow at pc = 16'h0042 -> next cycle: flush = 1, pc_target = 16'h0100, epc = 16'h0042, cause = 01, ie = 0; following cycle mode = 1.
REQ-041 overflow and user_input together in USER with ie = 1 -> cause = 01; after eret and return, user input taken with cause = 10 and a single ack_user pulse.
REQ-042 ie = 0 with overflow -> no flush, mode stays 0; ie_set and ie_clr in the same cycle -> ie = 0.
REQ-043 In KERNEL, eret with epc = 16'h0042 -> RETURN: pc_target = 16'h0042, flush = 1, ie = 1; next cycle mode = 0, cause = 00.
REQ-044 Reset asserted during TAKE -> next cycle: state USER, pc_sel = 0, mode = 0, ie = 0.
REQ-045 COPROC_TIMER_EN, TIMER_PERIOD = 4, ie = 1 -> take with cause = 11 four cycles after enable; without the macro, no take occurs over 100 cycles.

Source files
------------

// File: rtl/exception_controller_pkg.sv
// Shared definitions for the exception controller: FSM encoding, cause codes
// and the default kernel handler entry address.
package coproc_pkg;

    localparam logic [1:0] ST_USER   = 2'd0;
    localparam logic [1:0] ST_TAKE   = 2'd1;
    localparam logic [1:0] ST_KERNEL = 2'd2;
    localparam logic [1:0] ST_RETURN = 2'd3;

    typedef enum logic [1:0] {
        CAUSE_NONE  = 2'b00,
        CAUSE_OVF   = 2'b01,
        CAUSE_USER  = 2'b10,
        CAUSE_TIMER = 2'b11
    } cause_e;

    localparam logic [15:0] HANDLER_ADDR_DEFAULT = 16'h0100;

endpackage

// File: rtl/exception_controller_if.sv
// Bundle between the CPU pipeline (master) and the exception controller (slave).
interface exception_controller_if #(
    parameter int PC_W = 16
);
    logic            overflow;
    logic            user_input;
    logic            ie_set;
    logic            ie_clr;
    logic            eret;
    logic [PC_W-1:0] pc;

    logic            mode;
    logic            flush;
    logic            pc_sel;
    logic [PC_W-1:0] pc_target;
    logic [PC_W-1:0] epc;
    logic [1:0]      cause;
    logic            ie;
    logic            ack_user;

    modport master (
        output overflow, user_input, ie_set, ie_clr, eret, pc,
        input  mode, flush, pc_sel, pc_target, epc, cause, ie, ack_user
    );

    modport slave (
        input  overflow, user_input, ie_set, ie_clr, eret, pc,
        output mode, flush, pc_sel, pc_target, epc, cause, ie, ack_user
    );
endinterface

// File: rtl/exception_controller_priority.sv
// Fixed-priority selection of the exception source: overflow > user > timer.
module exc_priority_encoder
    import coproc_pkg::*;
(
    input  logic       overflow,
    input  logic       user,
    input  logic       timer,
    output logic       take,
    output logic [1:0] code
);
    always_comb begin
        take = overflow | user | timer;
        code = CAUSE_NONE;
        if (overflow) begin
            code = CAUSE_OVF;
        end else if (user) begin
            code = CAUSE_USER;
        end else if (timer) begin
            code = CAUSE_TIMER;
        end
    end
endmodule

// File: rtl/exception_controller.sv
// Exception/interrupt sequencer: redirects fetch to the kernel handler and back.
// Optional periodic timer interrupt source is built when COPROC_TIMER_EN is defined.
//
// state  | meaning
// USER   | user code running, sources may be taken when ie = 1
// TAKE   | one-cycle squash + redirect to HANDLER_ADDR
// KERNEL | handler running, waits for eret
// RETURN | one-cycle squash + redirect to epc, interrupts re-enabled
module exception_controller
    import coproc_pkg::*;
#(
    parameter int              PC_W         = 16,
    parameter logic [PC_W-1:0] HANDLER_ADDR = PC_W'(HANDLER_ADDR_DEFAULT),
    parameter int              TIMER_PERIOD = 1000
) (
    input logic                 clk,
    input logic                 reset,
    exception_controller_if.slave bus
);
    logic [1:0]      state;
    logic [1:0]      stateNext;
    logic            ieReg;
    logic            userPend;
    logic            timerPend;
    logic [PC_W-1:0] epcReg;
    logic [1:0]      causeReg;
    logic            srcValid;
    logic [1:0]      winCode;
    logic            takeNow;
    logic            ackUser;
    logic            redirect;

    if (TIMER_PERIOD < 1) begin : g_bad_period
        $error("TIMER_PERIOD must be at least 1");
    end

    exc_priority_encoder uEnc (
        .overflow (bus.overflow),
        .user     (userPend),
        .timer    (timerPend),
        .take     (srcValid),
        .code     (winCode)
    );

    assign takeNow  = (state == ST_USER) && ieReg && srcValid;
    assign ackUser  = (state == ST_TAKE) && (causeReg == CAUSE_USER);
    assign redirect = (state == ST_TAKE) || (state == ST_RETURN);

    always_comb begin
        stateNext = state;
        case (state)
            ST_USER:   if (takeNow) stateNext = ST_TAKE;
            ST_TAKE:   stateNext = ST_KERNEL;
            ST_KERNEL: if (bus.eret) stateNext = ST_RETURN;
            ST_RETURN: stateNext = ST_USER;
            default:   stateNext = ST_USER;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_USER;
            ieReg    <= 1'b0;
            userPend <= 1'b0;
            epcReg   <= '0;
            causeReg <= CAUSE_NONE;
        end else begin
            state    <= stateNext;
            userPend <= ackUser ? 1'b0 : (userPend | bus.user_input);
            if (takeNow) begin
                epcReg   <= bus.pc;
                causeReg <= winCode;
                ieReg    <= 1'b0;
            end else if (state == ST_USER) begin
                // clear wins when both strobes arrive together
                if (bus.ie_clr) begin
                    ieReg <= 1'b0;
                end else if (bus.ie_set) begin
                    ieReg <= 1'b1;
                end
            end else if (state == ST_KERNEL && bus.eret) begin
                ieReg <= 1'b1;
            end
            if (state == ST_RETURN) begin
                causeReg <= CAUSE_NONE;
            end
        end
    end

`ifdef COPROC_TIMER_EN
    localparam int CNT_W = (TIMER_PERIOD > 1) ? $clog2(TIMER_PERIOD) : 1;

    logic [CNT_W-1:0] timerCnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            timerCnt  <= '0;
            timerPend <= 1'b0;
        end else begin
            if (takeNow && winCode == CAUSE_TIMER) begin
                timerPend <= 1'b0;
            end
            // a wrap in the same cycle as a timer take re-arms the request
            if (state == ST_USER && ieReg) begin
                if (timerCnt == CNT_W'(TIMER_PERIOD - 1)) begin
                    timerCnt  <= '0;
                    timerPend <= 1'b1;
                end else begin
                    timerCnt <= timerCnt + CNT_W'(1);
                end
            end
        end
    end
`else
    assign timerPend = 1'b0;
`endif

    assign bus.mode      = (state != ST_USER);
    assign bus.flush     = redirect;
    assign bus.pc_sel    = redirect;
    assign bus.pc_target = (state == ST_TAKE)   ? HANDLER_ADDR :
                           (state == ST_RETURN) ? epcReg       : '0;
    assign bus.epc       = epcReg;
    assign bus.cause     = causeReg;
    assign bus.ie        = ieReg;
    assign bus.ack_user  = ackUser;

endmodule

// File: tb/tb_exception_controller.sv
// Scoreboard bench for exception_controller: directed scenarios plus random
// traffic, checked cycle by cycle against a behavioural model.
module tb_exception_controller;
    localparam int PC_W = 16;
    localparam int TP   = 4;

    logic clk = 1'b0;
    logic reset;

    exception_controller_if #(.PC_W(PC_W)) bus ();

    exception_controller #(
        .PC_W         (PC_W),
        .HANDLER_ADDR (16'h0100),
        .TIMER_PERIOD (TP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        mode;
        logic        flush;
        logic        pcSel;
        logic [15:0] target;
        logic [15:0] epc;
        logic [1:0]  cause;
        logic        ie;
        logic        ack;
    } exp_t;

    exp_t expQ[$];
    int   nCompared   = 0;
    int   nMismatched = 0;

    // Model: phase 0 user code, 1 entering handler, 2 inside handler, 3 leaving handler
    int          phase = 0;
    bit          mValid = 0;
    bit          mIe, mUserPend, mTimerPend, mAck;
    logic [15:0] mEpc;
    logic [1:0]  mCause;
    int          mTicks;

    function automatic exp_t modelOutputs();
        exp_t e;
        e.mode   = (phase != 0);
        e.flush  = (phase == 1) || (phase == 3);
        e.pcSel  = e.flush;
        e.target = (phase == 1) ? 16'h0100 : (phase == 3) ? mEpc : 16'h0000;
        e.epc    = mEpc;
        e.cause  = mCause;
        e.ie     = mIe;
        e.ack    = mAck;
        return e;
    endfunction

    task automatic modelStep(input bit rst, input bit ovf, input bit ui, input bit set,
                             input bit clr, input bit er, input logic [15:0] pcv);
        int          nPhase, nTicks;
        bit          nIe, nUp, nTp, nAck;
        logic [1:0]  nCause;
        logic [15:0] nEpc;
        if (rst) begin
            phase = 0; mIe = 0; mUserPend = 0; mTimerPend = 0; mAck = 0;
            mEpc = 16'h0; mCause = 2'b00; mTicks = 0; mValid = 1;
            return;
        end
        nPhase = phase; nIe = mIe; nTp = mTimerPend; nAck = 0;
        nCause = mCause; nEpc = mEpc; nTicks = mTicks;
        nUp = mAck ? 1'b0 : (mUserPend | ui);
        if (phase == 0) begin
            if (mIe && (ovf || mUserPend || mTimerPend)) begin
                nPhase = 1; nIe = 0; nEpc = pcv;
                if (ovf) nCause = 2'b01;
                else if (mUserPend) begin nCause = 2'b10; nAck = 1; end
                else begin nCause = 2'b11; nTp = 0; end
            end else if (clr) nIe = 0;
            else if (set) nIe = 1;
`ifdef COPROC_TIMER_EN
            if (mIe) begin
                nTicks = mTicks + 1;
                if (nTicks == TP) begin nTicks = 0; nTp = 1; end
            end
`endif
        end else if (phase == 1) begin
            nPhase = 2;
        end else if (phase == 2) begin
            if (er) begin nPhase = 3; nIe = 1; end
        end else begin
            nPhase = 0; nCause = 2'b00;
        end
        phase = nPhase; mIe = nIe; mUserPend = nUp; mTimerPend = nTp; mAck = nAck;
        mCause = nCause; mEpc = nEpc; mTicks = nTicks;
    endtask

    task automatic cycle(input bit rst, input bit ovf, input bit ui, input bit set,
                         input bit clr, input bit er, input logic [15:0] pcv);
        @(negedge clk);
        if (mValid) expQ.push_back(modelOutputs());
        reset          = rst;
        bus.overflow   = ovf;
        bus.user_input = ui;
        bus.ie_set     = set;
        bus.ie_clr     = clr;
        bus.eret       = er;
        bus.pc         = pcv;
        modelStep(rst, ovf, ui, set, clr, er, pcv);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 16'h0010);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        nCompared++;
        if (act !== req) begin
            nMismatched++;
            $display("FAIL %s: got %0h required %0h at t=%0t", nm, act, req, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                check("mode",      32'(bus.mode),      32'(e.mode));
                check("flush",     32'(bus.flush),     32'(e.flush));
                check("pc_sel",    32'(bus.pc_sel),    32'(e.pcSel));
                check("pc_target", 32'(bus.pc_target), 32'(e.target));
                check("epc",       32'(bus.epc),       32'(e.epc));
                check("cause",     32'(bus.cause),     32'(e.cause));
                check("ie",        32'(bus.ie),        32'(e.ie));
                check("ack_user",  32'(bus.ack_user),  32'(e.ack));
            end
        end
    end

    initial begin : stimulus
        reset = 1'b1;
        bus.overflow = 0; bus.user_input = 0; bus.ie_set = 0;
        bus.ie_clr = 0; bus.eret = 0; bus.pc = '0;
        cycle(1, 0, 0, 0, 0, 0, 16'h0000);
        cycle(1, 0, 0, 0, 0, 0, 16'h0000);
        idle(2);

        // interrupts disabled: overflow dropped, simultaneous set/clr leaves ie low
        cycle(0, 1, 0, 0, 0, 0, 16'h0042);
        idle(2);
        cycle(0, 0, 0, 1, 1, 0, 16'h0010);
        idle(1);

        // overflow take at 0x0042, handler, eret back
        cycle(0, 0, 0, 1, 0, 0, 16'h0010);
        cycle(0, 1, 0, 0, 0, 0, 16'h0042);
        cycle(0, 1, 0, 1, 0, 0, 16'h0050);
        idle(2);
        cycle(0, 0, 0, 0, 0, 1, 16'h0110);
        idle(2);

        // overflow beats user input; user taken after return with one ack
        cycle(0, 1, 1, 0, 0, 0, 16'h0042);
        idle(3);
        cycle(0, 0, 0, 0, 0, 1, 16'h0120);
        idle(5);
        cycle(0, 0, 0, 0, 0, 1, 16'h0130);
        idle(2);

        // reset while redirecting to the handler
        cycle(0, 1, 0, 0, 0, 0, 16'h0077);
        cycle(1, 0, 0, 0, 0, 0, 16'h0000);
        idle(2);

        // pending user request, ie_set takes effect one cycle later
        cycle(0, 0, 1, 0, 0, 0, 16'h0010);
        idle(2);
        cycle(0, 0, 0, 1, 0, 0, 16'h0020);
        idle(3);
        cycle(0, 0, 0, 0, 0, 1, 16'h0130);
        idle(2);

        // timer: takes only when the timer source is built in
        cycle(0, 0, 0, 1, 0, 0, 16'h0010);
        idle(100);
        cycle(0, 0, 0, 0, 0, 1, 16'h0140);
        idle(3);

        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(99, 0) < 1,
                  $urandom_range(99, 0) < 15,
                  $urandom_range(99, 0) < 10,
                  $urandom_range(99, 0) < 20,
                  $urandom_range(99, 0) < 8,
                  $urandom_range(99, 0) < 25,
                  16'($urandom));
        end
        idle(3);
        #2;
        check("scoreboard_drain", 32'(expQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
